// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and its MDU busy timer.
package pipeline_hazard_ctrl_pkg;

  // Busy-timer FSM encodings, common to the timer and the sequencer top.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } mdu_state_e;

  // Register $zero never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default MDU latency in cycles (legal 1..255) and stall counter width.
  localparam int MDU_LAT_DEF = 8;
  localparam int CNT_W_DEF   = 16;

  // True when an ID source operand that is actually read names the given register.
  function automatic logic src_matches(input logic uses, input logic [4:0] src,
                                       input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mdu_busy_timer.sv
// MDU busy timer: once started, holds Busy high for exactly MDU_LAT cycles.
module mdu_busy_timer
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Start,
  output logic Busy
);

  localparam int CW = (MDU_LAT < 2) ? 1 : $clog2(MDU_LAT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MDU_LAT - 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next state: load the timer on Start, count down in WAIT, leave when it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (Start) begin
          state_d = ST_WAIT;
          cnt_d   = LOAD_VAL;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Busy = (state_q == ST_WAIT);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect and MDU hazards.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_MulDiv,
  input  logic             ID_ReadHiLo,
  input  logic             EX_MemtoReg,
  input  logic             EX_RegWr,
  input  logic [4:0]       EX_Rw,
  input  logic             MEM_PCSrc,
  output logic             PC_Wr,
  output logic             IFID_Wr,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             MDU_Start,
  output logic             MDU_Busy,
  output logic [CNT_W-1:0] Stall_Cnt
);

  logic             start_pend_q, start_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use, mdu_haz, stall;

  // The timer is fed only by a start that survived the redirect check.
  mdu_busy_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_timer (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (MDU_Start),
    .Busy  (MDU_Busy)
  );

  assign MDU_Start = start_pend_q & ~MEM_PCSrc;

  // Hazard detection; a redirect kills the ID instruction so it never stalls.
  always_comb begin
    load_use = EX_MemtoReg && EX_RegWr && (EX_Rw != REG_ZERO) &&
               (src_matches(ID_UsesRs, ID_Rs, EX_Rw) ||
                src_matches(ID_UsesRt, ID_Rt, EX_Rw));
    mdu_haz  = (ID_MulDiv || ID_ReadHiLo) && (MDU_Busy || MDU_Start);
    stall    = (load_use || mdu_haz) && !MEM_PCSrc;
  end

  // Output muxing: redirect flushes everything younger, stall holds PC/IF-ID and bubbles ID/EX.
  always_comb begin
    PC_Wr       = 1'b1;
    IFID_Wr     = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    if (MEM_PCSrc) begin
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
    end else if (stall) begin
      PC_Wr      = 1'b0;
      IFID_Wr    = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

  // Next-state for the pending start and the saturating stall counter.
  always_comb begin
    start_pend_d = ID_MulDiv && !stall && !MEM_PCSrc;
    stall_cnt_d  = stall_cnt_q;
    if (!PC_Wr && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Control registers; reset drops any pending start and clears the counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      start_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      start_pend_q <= start_pend_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a per-cycle expectation scoreboard.
module tb_pipeline_hazard_ctrl;

  localparam logic [4:0] RUNV  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] REDIR = 5'b11111;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rw;
  logic       id_urs, id_urt, id_md, id_hl, ex_mtr, ex_rwr, pcs;

  logic        pc_wr, ifid_wr, ifid_fl, idex_fl, exmem_fl, st, bz;
  logic [15:0] cnt16;
  logic        pc_wr4, ifid_wr4, ifid_fl4, idex_fl4, exmem_fl4, st4, bz4;
  logic [3:0]  cnt4;

  typedef struct {
    string      nm;
    bit         chk;
    logic [4:0] ctl;
    logic       st;
    logic       bz;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ecnt   = 0;

  pipeline_hazard_ctrl dut (
    .Clk(clk), .Rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRs(id_urs),
    .ID_UsesRt(id_urt), .ID_MulDiv(id_md), .ID_ReadHiLo(id_hl),
    .EX_MemtoReg(ex_mtr), .EX_RegWr(ex_rwr), .EX_Rw(ex_rw), .MEM_PCSrc(pcs),
    .PC_Wr(pc_wr), .IFID_Wr(ifid_wr), .IFID_Flush(ifid_fl), .IDEX_Flush(idex_fl),
    .EXMEM_Flush(exmem_fl), .MDU_Start(st), .MDU_Busy(bz), .Stall_Cnt(cnt16)
  );

  pipeline_hazard_ctrl #(.MDU_LAT(8), .CNT_W(4)) dut4 (
    .Clk(clk), .Rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRs(id_urs),
    .ID_UsesRt(id_urt), .ID_MulDiv(id_md), .ID_ReadHiLo(id_hl),
    .EX_MemtoReg(ex_mtr), .EX_RegWr(ex_rwr), .EX_Rw(ex_rw), .MEM_PCSrc(pcs),
    .PC_Wr(pc_wr4), .IFID_Wr(ifid_wr4), .IFID_Flush(ifid_fl4), .IDEX_Flush(idex_fl4),
    .EXMEM_Flush(exmem_fl4), .MDU_Start(st4), .MDU_Busy(bz4), .Stall_Cnt(cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h", nm, f, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      if (me.chk) begin
        chk(me.nm, "ctl", 32'({pc_wr, ifid_wr, ifid_fl, idex_fl, exmem_fl}), 32'(me.ctl));
        chk(me.nm, "MDU_Start", 32'(st), 32'(me.st));
        chk(me.nm, "MDU_Busy", 32'(bz), 32'(me.bz));
        chk(me.nm, "Stall_Cnt", 32'(cnt16), 32'(me.cnt));
        chk(me.nm, "ctl_w4", 32'({pc_wr4, ifid_wr4, ifid_fl4, idex_fl4, exmem_fl4, st4, bz4}),
            32'({me.ctl, me.st, me.bz}));
        chk(me.nm, "Stall_Cnt_w4", 32'(cnt4), 32'((me.cnt > 15) ? 15 : me.cnt));
      end
    end
  end

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rw = 5'd0;
    id_urs = 1'b0; id_urt = 1'b0; id_md = 1'b0; id_hl = 1'b0;
    ex_mtr = 1'b0; ex_rwr = 1'b0; pcs = 1'b0;
  endtask

  // Push this cycle's expectation, then advance one clock and track the stall count.
  task automatic step(input string nm, input bit c, input logic [4:0] ctl,
                      input logic s, input logic b);
    exp_t e;
    e.nm = nm; e.chk = c; e.ctl = ctl; e.st = s; e.bz = b; e.cnt = ecnt;
    sb.push_back(e);
    @(posedge clk);
    if (rst) ecnt = 0;
    else if (!ctl[4]) ecnt++;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    // Reset
    step("reset", 1, RUNV, 0, 0);
    rst = 1'b0;
    step("idle0", 1, RUNV, 0, 0);
    // Load-use hazards
    ex_mtr = 1; ex_rwr = 1; ex_rw = 5'd8; id_rs = 5'd8; id_urs = 1;
    step("lu_rs", 1, STALL, 0, 0);
    idle();
    step("lu_after", 1, RUNV, 0, 0);
    ex_mtr = 1; ex_rwr = 1; ex_rw = 5'd0; id_rs = 5'd0; id_urs = 1;
    step("lu_r0", 1, RUNV, 0, 0);
    ex_rw = 5'd8; id_rs = 5'd8; id_urs = 0;
    step("lu_nouse", 1, RUNV, 0, 0);
    id_urt = 1; id_rt = 5'd8;
    step("lu_rt", 1, STALL, 0, 0);
    ex_rwr = 0;
    step("lu_nowr", 1, RUNV, 0, 0);
    ex_rwr = 1; ex_mtr = 0;
    step("lu_noload", 1, RUNV, 0, 0);
    // Redirect beats load-use
    ex_mtr = 1; pcs = 1;
    step("redir_lu", 1, REDIR, 0, 0);
    idle();
    step("idle1", 1, RUNV, 0, 0);
    // MDU start, busy window, HI/LO read stalls
    id_md = 1;
    step("md_t", 1, RUNV, 0, 0);
    id_md = 0; id_hl = 1;
    step("md_t1", 1, STALL, 1, 0);
    for (int k = 2; k <= 9; k++) step("md_busy", 1, STALL, 0, 1);
    step("md_t10", 1, RUNV, 0, 0);
    idle();
    step("md_idle", 1, RUNV, 0, 0);
    // Back-to-back mult/div
    id_md = 1;
    step("b2b_t", 1, RUNV, 0, 0);
    step("b2b_t1", 1, STALL, 1, 0);
    for (int k = 2; k <= 9; k++) step("b2b_busy", 1, STALL, 0, 1);
    step("b2b_adv", 1, RUNV, 0, 0);
    id_md = 0;
    step("b2b_start", 1, RUNV, 1, 0);
    for (int k = 0; k < 8; k++) step("b2b_busy2", 1, RUNV, 0, 1);
    step("b2b_done", 1, RUNV, 0, 0);
    // Squashed start
    id_md = 1;
    step("sq_t", 1, RUNV, 0, 0);
    id_md = 0; pcs = 1;
    step("sq_t1", 1, REDIR, 0, 0);
    pcs = 0;
    for (int k = 0; k < 3; k++) step("sq_idle", 1, RUNV, 0, 0);
    // Redirect during WAIT leaves the MDU running
    id_md = 1;
    step("rw_t", 1, RUNV, 0, 0);
    id_md = 0;
    step("rw_t1", 1, RUNV, 1, 0);
    step("rw_t2", 1, RUNV, 0, 1);
    step("rw_t3", 1, RUNV, 0, 1);
    pcs = 1;
    step("rw_t4", 1, REDIR, 0, 1);
    pcs = 0;
    for (int k = 5; k <= 9; k++) step("rw_busy", 1, RUNV, 0, 1);
    step("rw_t10", 1, RUNV, 0, 0);
    // Reset mid-MDU
    id_md = 1;
    step("rm_t", 1, RUNV, 0, 0);
    id_md = 0;
    step("rm_t1", 1, RUNV, 1, 0);
    for (int k = 2; k <= 4; k++) step("rm_busy", 1, RUNV, 0, 1);
    rst = 1;
    step("rm_t5", 1, RUNV, 0, 1);
    rst = 0;
    step("rm_t6", 1, RUNV, 0, 0);
    // Reset while a start is pending
    id_md = 1;
    step("rp_t", 1, RUNV, 0, 0);
    id_md = 0; rst = 1;
    step("rp_rst", 1, RUNV, 1, 0);
    rst = 0;
    step("rp_t2", 1, RUNV, 0, 0);
    step("rp_t3", 1, RUNV, 0, 0);
    // Counter saturation
    ex_mtr = 1; ex_rwr = 1; ex_rw = 5'd8; id_rs = 5'd8; id_urs = 1;
    for (int k = 0; k < 20; k++) step("sat", 1, STALL, 0, 0);
    idle();
    step("sat_end", 1, RUNV, 0, 0);
    step("sat_hold", 1, RUNV, 0, 0);
    // Drain the scoreboard
    repeat (2) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
